// File: rtl/alu_exec_unit_pkg.sv
// Shared opcode, FSM state and writeback-enable types for the MiniAlu execute stage.
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_STO  = 4'd3,
    OP_BLE  = 4'd4,
    OP_JMP  = 4'd5,
    OP_LED  = 4'd6,
    OP_SMUL = 4'd7,
    OP_UMUL = 4'd8,
    OP_MAC  = 4'd9,
    OP_ACLR = 4'd10
  } aluOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } fsmState_e;

  typedef struct packed {
    logic we;
    logic weHi;
    logic branch;
    logic led;
  } wbEnables_t;

endpackage

// File: rtl/alu_exec_unit_mul_seq_core.sv
// Radix-2 shift-add multiplier: unsigned magnitudes in, 2W-bit product after W steps.
module alu_exec_unit_mul_seq_core
#(
  parameter int unsigned DATA_WIDTH = 16
)
(
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     multiplicand,
  input  logic [DATA_WIDTH-1:0]     multiplier,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      done_c
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic [CW-1:0] count;
  logic          busy;
  logic [W-1:0]  mcand;
  logic [W:0]    partial;

  // Upper half plus multiplicand when the current multiplier bit (product LSB) is set
  assign partial = {1'b0, product[2*W-1:W]} + ({1'b0, mcand} & {(W+1){product[0]}});
  assign done_c  = busy && (count == CW'(W - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      mcand   <= multiplicand;
      product <= {W'(0), multiplier};
    end else if (busy) begin
      product <= {partial, product[W-1:1]};
      count   <= count + CW'(1);
      if (done_c) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// MiniAlu execute stage: single-cycle ALU plus multi-cycle signed/unsigned multiply with stall handshake.
// Optional accumulator (MAC/ACLR opcodes) is built when ALU_MAC_EN is defined.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
)
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [3:0]            iOperation,
  input  logic [ADDR_WIDTH-1:0] iDestination,
  input  logic [DATA_WIDTH-1:0] iOperandA,
  input  logic [DATA_WIDTH-1:0] iOperandB,
  input  logic [DATA_WIDTH-1:0] iImmediate,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oResultLo,
  output logic [DATA_WIDTH-1:0] oResultHi,
  output logic                  oWriteEnable,
  output logic                  oWriteHiEn,
  output logic                  oBranchTaken,
  output logic                  oLedEnable,
  output logic [ADDR_WIDTH-1:0] oDestination
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  fsmState_e             state, nxtState;
  logic                  readyQ, nxtReady;
  logic                  validQ, nxtValid;
  wbEnables_t            enQ, nxtEn;
  logic [W-1:0]          loQ, nxtLo;
  logic [W-1:0]          hiQ, nxtHi;
  logic [ADDR_WIDTH-1:0] destQ, nxtDest;
  logic                  negQ, nxtNeg;
`ifdef ALU_MAC_EN
  logic                  macQ, nxtMac;
  logic [PW-1:0]         accQ, nxtAcc;
`endif

  logic                  signedMul;
  logic                  mulStart;
  logic                  mulDone;
  logic [W-1:0]          magA, magB;
  logic [PW-1:0]         product, signedProd;

`ifdef ALU_MAC_EN
  assign signedMul = (iOperation == OP_SMUL) || (iOperation == OP_MAC);
`else
  assign signedMul = (iOperation == OP_SMUL);
`endif

  // Signed ops feed magnitudes to the engine; -2^(W-1) maps to 2^(W-1), which still fits in W bits
  assign magA = (signedMul && iOperandA[W-1]) ? (~iOperandA + W'(1)) : iOperandA;
  assign magB = (signedMul && iOperandB[W-1]) ? (~iOperandB + W'(1)) : iOperandB;
  assign signedProd = negQ ? (~product + PW'(1)) : product;

  alu_exec_unit_mul_seq_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mulCore (
    .Clock        (Clock),
    .Reset        (Reset),
    .start        (mulStart),
    .multiplicand (magA),
    .multiplier   (magB),
    .product      (product),
    .done_c       (mulDone)
  );

  // Next-state and next-output logic
  always_comb begin
    nxtState = state;
    nxtValid = 1'b0;
    nxtEn    = '0;
    nxtLo    = loQ;
    nxtHi    = hiQ;
    nxtDest  = destQ;
    nxtNeg   = negQ;
    mulStart = 1'b0;
`ifdef ALU_MAC_EN
    nxtMac   = macQ;
    nxtAcc   = accQ;
`endif

    case (state)
      IDLE: begin
        if (iValid) begin
          nxtDest  = iDestination;
          nxtValid = 1'b1;
          case (iOperation)
            OP_ADD: begin
              nxtEn.we = 1'b1;
              nxtLo    = iOperandA + iOperandB;
            end
            OP_SUB: begin
              nxtEn.we = 1'b1;
              nxtLo    = iOperandA - iOperandB;
            end
            OP_STO: begin
              nxtEn.we = 1'b1;
              nxtLo    = iImmediate;
            end
            OP_BLE:  nxtEn.branch = (iOperandA <= iOperandB);
            OP_JMP:  nxtEn.branch = 1'b1;
            OP_LED:  nxtEn.led    = 1'b1;
            OP_SMUL, OP_UMUL: begin
              nxtValid = 1'b0;
              mulStart = 1'b1;
              nxtState = MUL;
              nxtNeg   = signedMul && (iOperandA[W-1] ^ iOperandB[W-1]);
`ifdef ALU_MAC_EN
              nxtMac   = 1'b0;
`endif
            end
`ifdef ALU_MAC_EN
            OP_MAC: begin
              nxtValid = 1'b0;
              mulStart = 1'b1;
              nxtState = MUL;
              nxtNeg   = iOperandA[W-1] ^ iOperandB[W-1];
              nxtMac   = 1'b1;
            end
            OP_ACLR: nxtAcc = '0;
`endif
            default: ;
          endcase
        end
      end
      MUL: begin
        if (mulDone) begin
          nxtState = DONE;
        end
      end
      DONE: begin
        nxtState   = IDLE;
        nxtValid   = 1'b1;
        nxtEn.we   = 1'b1;
        nxtEn.weHi = 1'b1;
        {nxtHi, nxtLo} = signedProd;
`ifdef ALU_MAC_EN
        if (macQ) begin
          nxtAcc         = accQ + signedProd;
          {nxtHi, nxtLo} = accQ + signedProd;
        end
`endif
      end
      default: nxtState = IDLE;
    endcase

    nxtReady = (nxtState == IDLE);
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      readyQ <= 1'b1;
      validQ <= 1'b0;
      enQ    <= '0;
      loQ    <= '0;
      hiQ    <= '0;
      destQ  <= '0;
      negQ   <= 1'b0;
`ifdef ALU_MAC_EN
      macQ   <= 1'b0;
      accQ   <= '0;
`endif
    end else begin
      state  <= nxtState;
      readyQ <= nxtReady;
      validQ <= nxtValid;
      enQ    <= nxtEn;
      loQ    <= nxtLo;
      hiQ    <= nxtHi;
      destQ  <= nxtDest;
      negQ   <= nxtNeg;
`ifdef ALU_MAC_EN
      macQ   <= nxtMac;
      accQ   <= nxtAcc;
`endif
    end
  end

  assign oReady       = readyQ;
  assign oValid       = validQ;
  assign oResultLo    = loQ;
  assign oResultHi    = hiQ;
  assign oWriteEnable = enQ.we;
  assign oWriteHiEn   = enQ.weHi;
  assign oBranchTaken = enQ.branch;
  assign oLedEnable   = enQ.led;
  assign oDestination = destQ;

endmodule
